// File: rtl/audio_pkg.sv
// Shared constants and types for the audio output path.
package audio_pkg;

    localparam int AUDIO_W = 8;
    localparam logic [AUDIO_W-1:0] AUDIO_MID = 8'h80;
    localparam int DEF_SAMPLE_DIV = 256;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [AUDIO_W-1:0] l;
        logic [AUDIO_W-1:0] r;
    } stereo_t;

endpackage

// File: rtl/sd_mod1.sv
// First-order sigma-delta modulator: emits s ones per 2^WIDTH cycles as a 1-bit stream.
module sd_mod1
    import audio_pkg::*;
#(
    parameter int WIDTH = AUDIO_W
)
(
    input  logic             clk_8m,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] s,
    output logic             pwm
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             pwm_q, pwm_d;
    logic [WIDTH:0]   sum_s;

    // Accumulate and take the carry; a disabled modulator parks at zero phase.
    always_comb begin
        sum_s = {1'b0, acc_q} + {1'b0, s};
        if (enable) begin
            acc_d = sum_s[WIDTH-1:0];
            pwm_d = sum_s[WIDTH];
        end else begin
            acc_d = {WIDTH{1'b0}};
            pwm_d = 1'b0;
        end
    end

    // Accumulator and output bit registers.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {WIDTH{1'b0}};
            pwm_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/audio_pwm_dac.sv
// Stereo PWM audio stage: sample FIFO, sample-period divider and two sigma-delta modulators.
module audio_pwm_dac
    import audio_pkg::*;
#(
    parameter int WIDTH      = AUDIO_W,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
)
(
    input  logic                          clk_8m,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              in_l,
    input  logic [WIDTH-1:0]              in_r,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          enable,
    input  logic                          mute,
    output logic                          pwm_l,
    output logic                          pwm_r,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam logic [DW-1:0]    DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [WIDTH-1:0] MID      = {1'b1, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [WIDTH-1:0] l;
        logic [WIDTH-1:0] r;
    } pair_t;

    pair_t            mem_q [FIFO_DEPTH];
    pair_t            mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DW-1:0]    div_q, div_d;
    logic [WIDTH-1:0] cur_l_q, cur_l_d, cur_r_q, cur_r_d;
    logic             tick_s, push_s, pop_s;
    logic [WIDTH-1:0] mod_l_s, mod_r_s;

    // FIFO bookkeeping, sample-period divider and current-sample update.
    always_comb begin
        tick_s   = enable && (div_q == DIV_LAST);
        push_s   = in_valid && (count_q < DEPTH_C);
        pop_s    = tick_s && (count_q != {CW{1'b0}});
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cur_l_d  = cur_l_q;
        cur_r_d  = cur_r_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = '{l: in_l, r: in_r};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            cur_l_d  = mem_q[rd_ptr_q].l;
            cur_r_d  = mem_q[rd_ptr_q].r;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (!enable) begin
            div_d = {DW{1'b0}};
        end else if (tick_s) begin
            div_d = {DW{1'b0}};
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // State registers; reset empties the FIFO and parks the outputs at midscale.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            div_q    <= {DW{1'b0}};
            cur_l_q  <= MID;
            cur_r_q  <= MID;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            div_q    <= div_d;
            cur_l_q  <= cur_l_d;
            cur_r_q  <= cur_r_d;
        end
    end

    assign in_ready   = (count_q < DEPTH_C);
    assign underrun   = tick_s && (count_q == {CW{1'b0}});
    assign fifo_level = count_q;
    assign mod_l_s    = mute ? MID : cur_l_q;
    assign mod_r_s    = mute ? MID : cur_r_q;

    sd_mod1 #(.WIDTH(WIDTH)) u_mod_l (
        .clk_8m (clk_8m),
        .rst_n  (rst_n),
        .enable (enable),
        .s      (mod_l_s),
        .pwm    (pwm_l)
    );

    sd_mod1 #(.WIDTH(WIDTH)) u_mod_r (
        .clk_8m (clk_8m),
        .rst_n  (rst_n),
        .enable (enable),
        .s      (mod_r_s),
        .pwm    (pwm_r)
    );

endmodule
